// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Inputs with a zero exponent are flushed to zero; results never go subnormal.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     dataA,
  input  logic [EXP_W+MAN_W:0]     dataB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;

  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EW-1:0]    BIAS_S   = EW'(BIAS);
  localparam logic signed [EW-1:0]    EMAX_S   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]    ZERO_S   = '0;

  // Valid bits shift through the stages; a stage loads when it is empty or
  // the stage after it is loading, so bubbles collapse.
  logic [3:1] vld_q;
  logic       ld1, ld2, ld3;

  assign ld3       = !vld_q[3] || out_ready;
  assign ld2       = !vld_q[2] || ld3;
  assign ld1       = !vld_q[1] || ld2;
  assign in_ready  = ld1;
  assign out_valid = vld_q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      if (ld1) vld_q[1] <= in_valid;
      if (ld2) vld_q[2] <= vld_q[1];
      if (ld3) vld_q[3] <= vld_q[2];
    end
  end

  // ---------------- S1: unpack, classify, sign, exponent sum
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               za, zb, ia, ib, na, nb;
  logic               s1_nan_d, s1_inf_d, s1_zero_d;
  logic signed [EW-1:0] s1_exp_d;

  assign {sa, ea, fa} = dataA;
  assign {sb, eb, fb} = dataB;
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == EXP_ONES) && (fa == '0);
  assign ib = (eb == EXP_ONES) && (fb == '0);
  assign na = (ea == EXP_ONES) && (fa != '0);
  assign nb = (eb == EXP_ONES) && (fb != '0);

  assign s1_nan_d  = na || nb || (ia && zb) || (za && ib);
  assign s1_inf_d  = ia || ib;
  assign s1_zero_d = za || zb;
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  logic                 s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [MAN_W:0]       s1_ma_q, s1_mb_q;

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_sign_q <= sa ^ sb;
      s1_nan_q  <= s1_nan_d;
      s1_inf_q  <= s1_inf_d;
      s1_zero_q <= s1_zero_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= {1'b1, fa};
      s1_mb_q   <= {1'b1, fb};
    end
  end

  // ---------------- S2: mantissa product
  logic [PW-1:0]        s2_prod_d;
  logic                 s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [PW-1:0]        s2_prod_q;

  assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  always_ff @(posedge clk) begin
    if (ld2 && vld_q[1]) begin
      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s1_nan_q;
      s2_inf_q  <= s1_inf_q;
      s2_zero_q <= s1_zero_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
    end
  end

  // ---------------- S3: normalise, round, pack, special-case select
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     mant;
  logic                 grd, sticky, rnd, inexact;
  logic [MAN_W:0]       mr;
  logic signed [EW-1:0] e_n, e_r;
  logic [W-1:0]         result_d, result_q;
  logic [3:0]           flags_d, flags_q;

  // Leading one sits at PW-1 or PW-2; shift so it is always just above norm.
  assign norm    = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
  assign e_n     = s2_exp_q + $signed({{(EW-1){1'b0}}, s2_prod_q[PW-1]});
  assign mant    = norm[PW-2:MAN_W+1];
  assign grd     = norm[MAN_W];
  assign sticky  = |norm[MAN_W-1:0];
  assign rnd     = grd && (sticky || mant[0]);
  assign inexact = grd || sticky;
  assign mr      = {1'b0, mant} + (MAN_W+1)'(rnd);
  assign e_r     = e_n + $signed({{(EW-1){1'b0}}, mr[MAN_W]});

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (s2_nan_q) begin
      result_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d  = 4'b1000;
    end else if (s2_inf_q) begin
      result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
    end else if (s2_zero_q) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (e_r >= EMAX_S) begin
      result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      flags_d  = 4'b0101;
    end else if (e_r <= ZERO_S) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
      flags_d  = 4'b0011;
    end else begin
      // On rounding carry-out the mantissa field wraps to zero, which is exact.
      result_d = {s2_sign_q, e_r[EXP_W-1:0], mr[MAN_W-1:0]};
      flags_d  = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (ld3 && vld_q[2]) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (single precision): arithmetic reference
// model, directed corner vectors, stall/reset scenarios and random traffic.
module tb_fp_mult_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dataA, dataB, result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  int          errors = 0;
  int          checks = 0;
  int          outs   = 0;
  logic [35:0] sbq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer product rounded by remainder comparison.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    bit s, za, zb, ia, ib, na, nb;
    int ea, eb, e, sh;
    longint unsigned p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (za && ib)) return {4'b1000, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'h0};
    if (za || zb) return {4'b0000, s, 31'h0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 0), s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] sp[8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                           32'h7FC00000, 32'h7F800001, 32'h00000123, 32'h7F7FFFFF};
    case ($urandom_range(0, 5))
      0: return $urandom();
      1: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      2: return sp[$urandom_range(0, 7)];
      3: return {1'($urandom), 8'($urandom_range(1, 20)), 23'($urandom)};
      4: return {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
      default: return {1'($urandom), 8'd127, 12'h0, 11'($urandom)};
    endcase
  endfunction

  // Monitor: pushes expected on input handshakes, pops on output handshakes.
  initial begin : monitor
    bit          stall = 0;
    logic [35:0] held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        stall = 0;
      end else begin
        if (stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_hold", 64'({flags, result}), 64'(held));
        end
        if (in_valid && in_ready) sbq.push_back(model(dataA, dataB));
        if (out_valid && out_ready) begin
          outs++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h with nothing pending", result);
          end else begin
            check("scoreboard", 64'({flags, result}), 64'(sbq.pop_front()));
          end
        end
        stall = out_valid && !out_ready;
        held  = {flags, result};
      end
    end
  end

  task automatic issue_chk(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] ef);
    int lat = 0;
    @(posedge clk);
    #1 in_valid = 1'b1; dataA = a; dataB = b; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({nm, "_latency"}, 64'(lat), 64'd3);
    check({nm, "_result"}, 64'(result), 64'(er));
    check({nm, "_flags"}, 64'(flags), 64'(ef));
  endtask

  task automatic stall_stream();
    logic [31:0] va[10], vb[10];
    int idx = 0, cyc = 0, o0 = outs, wait_c = 0;
    bit acc = 0, saw_block = 0;
    for (int i = 0; i < 10; i++) begin
      va[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      vb[i] = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    end
    forever begin
      @(posedge clk);
      if (acc) idx++;
      cyc++;
      #1;
      if (idx == 10 || cyc > 200) break;
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = 1'b1;
      dataA = va[idx];
      dataB = vb[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) saw_block = 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (outs - o0 < 10 && wait_c < 40) begin
      @(negedge clk);
      wait_c++;
    end
    check("stall_issued", 64'(idx), 64'd10);
    check("stall_in_ready_drop", 64'(saw_block), 64'd1);
    check("stall_delivered", 64'(outs - o0), 64'd10);
  endtask

  initial begin
    int o0, wait_c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dataA = '0; dataB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'({out_valid, flags, result}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    issue_chk("mul_2x3",    32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
    issue_chk("mul_1p5sq",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    issue_chk("mul_ulp",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    issue_chk("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    issue_chk("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    issue_chk("overflow",   32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    issue_chk("underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    issue_chk("nzero_x_2",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    issue_chk("nan_in",     32'hFFC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    issue_chk("denorm_in",  32'h00000123, 32'h7F000000, 32'h00000000, 4'b0000);

    stall_stream();

    // Two ops in flight when reset hits: neither may emerge.
    @(posedge clk);
    #1 in_valid = 1'b1; dataA = 32'h3FC00000; dataB = 32'h40400000;
    @(posedge clk);
    #1 dataA = 32'h40400000; dataB = 32'h40400000;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1; o0 = outs;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_flush_state", 64'({out_valid, flags, result}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    issue_chk("post_reset", 32'h40800000, 32'hC0000000, 32'hC1000000, 4'b0000);
    check("rst_no_emit", 64'(outs - o0), 64'd1);

    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      dataA     = rnd_op();
      dataB     = rnd_op();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    wait_c = 0;
    while ((sbq.size() != 0 || out_valid) && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check("random_drain", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (legal range 5..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width, hidden bit excluded (legal range 10..52).
REQ-003 SHALL define W = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1 as derived localparams.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand pair present.
REQ-007 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port dataA  input  W  operand A: {sign, exponent, mantissa}.
REQ-009 SHALL have port dataB  input  W  operand B, same format.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  W  product.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-014 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/classify/sign XOR/exponent sum; S2 (MAN_W+1)x(MAN_W+1) mantissa product; S3 normalise, round, pack, special-case select.
REQ-016 SHALL present a result on out_valid exactly 3 cycles after acceptance when out_ready is held high; throughput 1 per cycle.
REQ-017 SHALL compute in_ready = !(stage-3 valid) || out_ready || any earlier stage empty, i.e. bubbles collapse; a full pipe with out_ready low SHALL freeze all stages and hold result/flags stable.
REQ-018 SHALL never drop, duplicate or reorder operations.
REQ-019 SHALL compute sign = signA XOR signB for all cases including zero and infinity; NaN results use sign 0.
REQ-020 SHALL form biased exponent as expA + expB - BIAS in EXP_W+2 signed bits; +1 when product bit 2*MAN_W+1 is set.
REQ-021 SHALL round to nearest, ties to even, using guard, round and sticky (OR of all lower product bits); mantissa carry-out from rounding SHALL increment the exponent.
REQ-022 SHALL treat operands with exponent 0 as zero (denormal inputs flushed, no flag).
REQ-023 SHALL set result to quiet NaN {0, all-ones exp, 1 then zeros} with invalid=1 when either operand is NaN, or one is infinity and the other zero.
REQ-024 SHALL return signed infinity, no flags, when an operand is infinity and the other is finite nonzero.
REQ-025 SHALL return signed infinity with overflow=1, inexact=1 when the rounded exponent >= 2^EXP_W-1.
REQ-026 SHALL return signed zero with underflow=1, inexact=1 when the rounded exponent <= 0 (no subnormal outputs).
REQ-027 SHALL set inexact=1 whenever any discarded product bit is nonzero.
REQ-028 SHALL return signed zero, no flags, when either operand is zero and no NaN case applies.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear all stage valids; out_valid=0, result=0, flags=0 on the following cycle.
REQ-030 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-031 SHALL discard in-flight operations when rst asserts mid-operation, with no result emitted for them.
REQ-032 SHALL give rst priority over any simultaneous handshake.

Verification
REQ-033 SHALL check 0x40000000 x 0x40400000, out_ready=1 -> result 0x40C00000, flags 0000, out_valid 3 cycles later.
REQ-034 SHALL check 0x3FC00000 x 0x3FC00000 -> 0x40100000; 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1.
REQ-035 SHALL check 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0000.
REQ-036 SHALL check 0x7F000000 x 0x40000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
REQ-037 SHALL check back-to-back stream of 10 ops with out_ready low cycles 4-8 -> in_ready drops once 3 ops held, result stable while stalled, all 10 results delivered in order.
REQ-038 SHALL check rst asserted with 2 ops in flight -> no result emitted; an op issued 1 cycle after reset releases appears 3 cycles later.
